// File: rtl/morph_frame_ctrl_if.sv
// Purpose: video-timing inputs, config inputs and status outputs of the morphology frame controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; the video source is free-running, qualified by the controller's ce.
interface morph_frame_ctrl_if;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [1:0]  cfg_mode;
  logic        cfg_valid;
  logic        err_clr;
  logic [1:0]  mode;
  logic        pipe_flush;
  logic        frame_start;
  logic [9:0]  pix_cnt;
  logic [10:0] line_cnt;
  logic        width_err;
  logic [1:0]  state;

  // Source / config side: drives video timing and config, observes status.
  modport master (
    output in_de, in_hsync, in_vsync, cfg_mode, cfg_valid, err_clr,
    input  mode, pipe_flush, frame_start, pix_cnt, line_cnt, width_err, state
  );

  // Controller side.
  modport slave (
    input  in_de, in_hsync, in_vsync, cfg_mode, cfg_valid, err_clr,
    output mode, pipe_flush, frame_start, pix_cnt, line_cnt, width_err, state
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Purpose: frame/line tracking, frame-aligned mode switching and line-width checking for the morphology pipeline.
// Latency: all outputs registered, one qualified cycle after the sampled input edge.
// Backpressure: none; ce=0 freezes every register, pulses stay one qualified cycle wide.
module morph_frame_ctrl #(
  parameter logic [9:0] H_SIZE   = 10'd83,
  parameter logic [1:0] MODE_RST = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  morph_frame_ctrl_if.slave vid
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_VBLANK = 2'b01;
  localparam logic [1:0] ST_LINE   = 2'b10;
  localparam logic [1:0] ST_HBLANK = 2'b11;

  localparam logic [9:0]  PIX_MAX  = 10'd1023;
  localparam logic [10:0] LINE_MAX = 11'd2047;

  logic        vs_q;
  logic        de_q;
  logic        vs_rise;
  logic        de_rise;
  logic        de_fall;

  logic [1:0]  pending;
  logic [1:0]  mode_r;
  logic        pipe_flush_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt;
  logic        frame_start_r;
  logic [9:0]  pix_cnt_r;
  logic [10:0] line_cnt_r;
  logic        width_err_r;
  logic        err_set;
  logic        line_begin;
  logic        line_count;

  assign vs_rise = vid.in_vsync & ~vs_q;
  assign de_rise = vid.in_de & ~de_q;
  assign de_fall = ~vid.in_de & de_q;

  // Edge-detect history; only advances on qualified cycles so edges are seen exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else if (ce) begin
      vs_q <= vid.in_vsync;
      de_q <= vid.in_de;
    end
  end

  // Config capture; the pending value only takes effect at a frame boundary, and a
  // strobe coinciding with vs_rise lands in pending after mode has already sampled it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= MODE_RST;
      mode_r       <= MODE_RST;
      pipe_flush_r <= 1'b0;
    end else if (ce) begin
      if (vid.cfg_valid) pending <= vid.cfg_mode;
      if (vs_rise)       mode_r  <= pending;
      pipe_flush_r <= vs_rise;
    end
  end

  // Next-state decode; vs_rise outranks any de edge, IDLE waits for a clean frame start.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:   if (vs_rise) state_nxt = ST_VBLANK;
      ST_VBLANK: if (vs_rise) state_nxt = ST_VBLANK;
                 else if (de_rise) state_nxt = ST_LINE;
      ST_LINE:   if (vs_rise) state_nxt = ST_VBLANK;
                 else if (de_fall) state_nxt = ST_HBLANK;
      ST_HBLANK: if (vs_rise) state_nxt = ST_VBLANK;
                 else if (de_rise) state_nxt = ST_LINE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and frame_start pulse on the first line of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      frame_start_r <= 1'b0;
    end else if (ce) begin
      state_r       <= state_nxt;
      frame_start_r <= (state_r == ST_VBLANK) && (state_nxt == ST_LINE);
    end
  end

  // pix_cnt holds the number of active pixels seen so far in the line: the first
  // pixel (the de_rise cycle) loads 1, so after an H_SIZE line it reads H_SIZE.
  assign line_begin = (state_r != ST_LINE) && (state_nxt == ST_LINE);
  assign line_count = (state_r == ST_LINE) && (state_nxt == ST_LINE) && vid.in_de;

  // Pixel and line counters, both saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r  <= '0;
      line_cnt_r <= '0;
    end else if (ce) begin
      if (line_begin)
        pix_cnt_r <= 10'd1;
      else if (line_count && (pix_cnt_r != PIX_MAX))
        pix_cnt_r <= pix_cnt_r + 10'd1;

      if (vs_rise)
        line_cnt_r <= '0;
      else if ((state_r == ST_LINE) && de_fall && (line_cnt_r != LINE_MAX))
        line_cnt_r <= line_cnt_r + 11'd1;
    end
  end

  // Error sources: wrong line length, line cut by vsync, active video during hsync.
  // Nothing is checked in IDLE so a reset mid-line cannot raise a false error.
  assign err_set = ((state_r == ST_LINE) && vs_rise) ||
                   ((state_r == ST_LINE) && de_fall && !vs_rise && (pix_cnt_r != H_SIZE)) ||
                   ((state_r != ST_IDLE) && vid.in_de && vid.in_hsync);

  // Sticky width error; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_err_r <= 1'b0;
    end else if (ce) begin
      if (err_set)
        width_err_r <= 1'b1;
      else if (vid.err_clr)
        width_err_r <= 1'b0;
    end
  end

  assign vid.mode        = mode_r;
  assign vid.pipe_flush  = pipe_flush_r;
  assign vid.frame_start = frame_start_r;
  assign vid.pix_cnt     = pix_cnt_r;
  assign vid.line_cnt    = line_cnt_r;
  assign vid.width_err   = width_err_r;
  assign vid.state       = state_r;

endmodule
